// File: rtl/sticky_scan_sequencer_pkg.sv
// rtl/sticky_scan_sequencer_pkg.sv - shared state type and chunk helpers for the sticky scan sequencer
package StickyScanPkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int numChunks(input int acc_width, input int chunk_width);
    return acc_width / chunk_width;
  endfunction

  // Number of bits of chunk k that lie inside the n LSBs, clamped to [0, chunk_width].
  function automatic int chunkCount(input int n, input int k, input int chunk_width);
    int base;
    base = k * chunk_width;
    if (n <= base) begin
      return 0;
    end else if (n - base >= chunk_width) begin
      return chunk_width;
    end else begin
      return n - base;
    end
  endfunction

endpackage

// File: rtl/sticky_scan_sequencer_reduce.sv
// rtl/sticky_scan_sequencer_reduce.sv - OR of the m least significant bits of one chunk
module ReduceOrTrailingBits #(
  parameter int WIDTH   = 32,
  parameter int M_WIDTH = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0]   chunk,
  input  logic [M_WIDTH-1:0] m,
  output logic               result
);

  logic [WIDTH-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (M_WIDTH'(i) < m);
    end
  end

  assign result = |(chunk & mask);

endmodule

// File: rtl/sticky_scan_sequencer.sv
// rtl/sticky_scan_sequencer.sv - chunk-serial sticky-bit engine between accumulator normalize and rounder
module sticky_scan_sequencer
  import StickyScanPkg::*;
#(
  parameter int ACC_WIDTH   = 128,
  parameter int CHUNK_WIDTH = 32,
  parameter int TAG_WIDTH   = 4,
  parameter int N_WIDTH     = $clog2(ACC_WIDTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [ACC_WIDTH-1:0] inValue,
  input  logic [N_WIDTH-1:0]   inN,
  input  logic [TAG_WIDTH-1:0] inTag,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 outSticky,
  output logic [TAG_WIDTH-1:0] outTag
);

  localparam int NUM_CHUNKS = numChunks(ACC_WIDTH, CHUNK_WIDTH);
  localparam int K_WIDTH    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int M_WIDTH    = $clog2(CHUNK_WIDTH) + 1;

  generate
    if (ACC_WIDTH % CHUNK_WIDTH != 0) begin : g_width_check
      $error("ACC_WIDTH must be a multiple of CHUNK_WIDTH");
    end
  endgenerate

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] value_q, value_d;
  logic [N_WIDTH-1:0]   n_q, n_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [K_WIDTH-1:0]   k_q, k_d;
  logic                 sticky_q, sticky_d;
  logic                 out_valid_q, out_valid_d;

  logic [N_WIDTH-1:0]     n_clamped;
  logic [CHUNK_WIDTH-1:0] chunk;
  logic [M_WIDTH-1:0]     chunk_m;
  logic                   chunk_or;
  logic                   last_chunk;
  logic                   accept;

  assign n_clamped  = (inN > N_WIDTH'(ACC_WIDTH)) ? N_WIDTH'(ACC_WIDTH) : inN;
  assign chunk      = value_q[int'(k_q)*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign chunk_m    = M_WIDTH'(chunkCount(int'(n_q), int'(k_q), CHUNK_WIDTH));
  assign last_chunk = int'(n_q) <= (int'(k_q) + 1) * CHUNK_WIDTH;

  ReduceOrTrailingBits #(
    .WIDTH(CHUNK_WIDTH)
  ) u_reduce (
    .chunk (chunk),
    .m     (chunk_m),
    .result(chunk_or)
  );

  // inReady is held low for the whole time reset is high, even though the FSM already sits in IDLE.
  assign inReady   = (state_q == ST_IDLE) && !reset;
  assign accept    = inValid && inReady;
  assign outValid  = out_valid_q;
  assign outSticky = sticky_q;
  assign outTag    = tag_q;

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    n_d         = n_q;
    tag_d       = tag_q;
    k_d         = k_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          value_d  = inValue;
          n_d      = n_clamped;
          tag_d    = inTag;
          sticky_d = 1'b0;
          k_d      = '0;
          if (n_clamped == '0) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        sticky_d = sticky_q | chunk_or;
        // Stop at the first set bit; later chunks cannot clear the sticky.
        if ((sticky_q | chunk_or) || last_chunk) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end else begin
          k_d = k_q + K_WIDTH'(1);
        end
      end
      ST_DONE: begin
        if (outReady) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      value_q     <= '0;
      n_q         <= '0;
      tag_q       <= '0;
      k_q         <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      n_q         <= n_d;
      tag_q       <= tag_d;
      k_q         <= k_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_sticky_scan_sequencer.sv
// tb/tb_sticky_scan_sequencer.sv - self-checking bench for sticky_scan_sequencer
module tb_sticky_scan_sequencer;

  localparam int ACC_W   = 128;
  localparam int CHUNK_W = 32;
  localparam int TAG_W   = 4;
  localparam int N_W     = $clog2(ACC_W) + 1;
  localparam int NUM_CH  = ACC_W / CHUNK_W;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             inValid = 1'b0;
  logic             inReady;
  logic [ACC_W-1:0] inValue = '0;
  logic [N_W-1:0]   inN = '0;
  logic [TAG_W-1:0] inTag = '0;
  logic             outValid;
  logic             outReady = 1'b0;
  logic             outSticky;
  logic [TAG_W-1:0] outTag;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  sticky_scan_sequencer #(
    .ACC_WIDTH  (ACC_W),
    .CHUNK_WIDTH(CHUNK_W),
    .TAG_WIDTH  (TAG_W),
    .N_WIDTH    (N_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .inValid  (inValid),
    .inReady  (inReady),
    .inValue  (inValue),
    .inN      (inN),
    .inTag    (inTag),
    .outValid (outValid),
    .outReady (outReady),
    .outSticky(outSticky),
    .outTag   (outTag)
  );

  typedef struct {
    logic [ACC_W-1:0] value;
    logic [N_W-1:0]   n;
    logic [TAG_W-1:0] tag;
    logic             exp_sticky;
    int               exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sticky is whether any of the first min(n,ACC_W) bits is set; scan length
  // is the chunk holding the lowest such bit, or all chunks touched by n if none is set.
  task automatic model(input logic [ACC_W-1:0] v, input int n, output logic s, output int lat);
    int nc;
    int first;
    nc    = (n > ACC_W) ? ACC_W : n;
    first = -1;
    for (int i = 0; i < nc; i++) begin
      if (v[i] && first < 0) first = i;
    end
    s = (first >= 0);
    if (nc == 0) lat = 1;
    else if (first >= 0) lat = 1 + first / CHUNK_W + 1;
    else lat = 1 + (nc + CHUNK_W - 1) / CHUNK_W;
  endtask

  task automatic issue(input logic [ACC_W-1:0] v, input logic [N_W-1:0] n, input logic [TAG_W-1:0] t);
    @(negedge clock);
    chk("in_ready_idle", inReady, 1'b1);
    inValid = 1'b1;
    inValue = v;
    inN     = n;
    inTag   = t;
    @(posedge clock);
    #1;
    inValid = 1'b0;
    inValue = {$urandom, $urandom, $urandom, $urandom};
    inN     = N_W'($urandom);
    inTag   = TAG_W'($urandom);
  endtask

  // Called right after the accepting edge; lat counts that edge as 1.
  task automatic wait_result(input int exp_lat, input logic exp_s, input logic [TAG_W-1:0] exp_t,
                             input int hold);
    int lat;
    lat = 1;
    @(negedge clock);
    while (!outValid && lat <= NUM_CH + 3) begin
      chk("in_ready_busy", inReady, 1'b0);
      @(negedge clock);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("out_valid", outValid, 1'b1);
    chk("out_sticky", outSticky, exp_s);
    chk("out_tag", outTag, exp_t);
    chk("in_ready_done", inReady, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk("hold_valid", outValid, 1'b1);
      chk("hold_sticky", outSticky, exp_s);
      chk("hold_tag", outTag, exp_t);
      chk("hold_in_ready", inReady, 1'b0);
    end
  endtask

  task automatic handshake();
    outReady = 1'b1;
    @(posedge clock);
    #1;
    outReady = 1'b0;
    @(negedge clock);
    chk("post_hs_valid", outValid, 1'b0);
    chk("post_hs_in_ready", inReady, 1'b1);
  endtask

  initial begin
    logic s;
    int   lat;
    logic [ACC_W-1:0] v;
    logic [N_W-1:0]   n;
    logic [TAG_W-1:0] t;

    vecs[0] = '{value: {ACC_W{1'b1}},            n: 8'd0,   tag: 4'h1, exp_sticky: 1'b0, exp_lat: 1};
    vecs[1] = '{value: ACC_W'(1) << 100,         n: 8'd101, tag: 4'h2, exp_sticky: 1'b1, exp_lat: 5};
    vecs[2] = '{value: ACC_W'(1) << 100,         n: 8'd100, tag: 4'h3, exp_sticky: 1'b0, exp_lat: 5};
    vecs[3] = '{value: ACC_W'(1),                n: 8'd128, tag: 4'h4, exp_sticky: 1'b1, exp_lat: 2};
    vecs[4] = '{value: ACC_W'(1) << 40,          n: 8'd128, tag: 4'h5, exp_sticky: 1'b1, exp_lat: 3};
    vecs[5] = '{value: ACC_W'(1) << 127,         n: 8'd200, tag: 4'h6, exp_sticky: 1'b1, exp_lat: 5};
    vecs[6] = '{value: '0,                       n: 8'd200, tag: 4'h7, exp_sticky: 1'b0, exp_lat: 5};
    vecs[7] = '{value: ACC_W'(1) << 31,          n: 8'd32,  tag: 4'h8, exp_sticky: 1'b1, exp_lat: 2};
    vecs[8] = '{value: ACC_W'(1) << 32,          n: 8'd32,  tag: 4'h9, exp_sticky: 1'b0, exp_lat: 2};

    #12;
    chk("rst_out_valid", outValid, 1'b0);
    chk("rst_out_sticky", outSticky, 1'b0);
    chk("rst_out_tag", outTag, 4'h0);
    chk("rst_in_ready", inReady, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", inReady, 1'b1);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].value, vecs[i].n, vecs[i].tag);
      wait_result(vecs[i].exp_lat, vecs[i].exp_sticky, vecs[i].tag, 1);
      handshake();
    end

    // Backpressure with a competing request waiting on the input side.
    issue(ACC_W'(1) << 70, 8'd128, 4'hA);
    wait_result(4, 1'b1, 4'hA, 0);
    for (int c = 0; c < 5; c++) begin
      inValid = 1'b1;
      inValue = ACC_W'(1);
      inN     = 8'd1;
      inTag   = 4'h5;
      @(negedge clock);
      chk("bp_valid", outValid, 1'b1);
      chk("bp_sticky", outSticky, 1'b1);
      chk("bp_tag", outTag, 4'hA);
      chk("bp_in_ready", inReady, 1'b0);
    end
    handshake();
    @(posedge clock);
    #1;
    inValid = 1'b0;
    wait_result(2, 1'b1, 4'h5, 0);
    handshake();

    // Reset during SCAN.
    issue('0, 8'd128, 4'h3);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_scan_valid", outValid, 1'b0);
    chk("rst_scan_in_ready", inReady, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_scan_rel_ready", inReady, 1'b1);

    // Reset during DONE drops outValid asynchronously.
    issue('0, 8'd128, 4'h3);
    wait_result(5, 1'b0, 4'h3, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_done_valid", outValid, 1'b0);
    chk("rst_done_tag", outTag, 4'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      chk("no_stale_valid", outValid, 1'b0);
    end
    issue(ACC_W'(1), 8'd1, 4'hC);
    wait_result(2, 1'b1, 4'hC, 0);
    handshake();

    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 3))
        0: v = '0;
        1: v = ACC_W'(1) << $urandom_range(0, ACC_W - 1);
        2: v = {$urandom, $urandom, $urandom, $urandom};
        default: v = {$urandom, $urandom, 64'h0};
      endcase
      n = N_W'($urandom_range(0, 255));
      t = TAG_W'($urandom);
      model(v, int'(n), s, lat);
      issue(v, n, t);
      wait_result(lat, s, t, $urandom_range(0, 2));
      handshake();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
